// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that merges N_CH functional-unit results onto one common data bus.
// Optional macro CDB_PERF_CNT_EN enables a saturating counter of contention cycles.
module cdb_arbiter #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [N_CH-1:0]            valid_in,
    input  logic [N_CH*DATA_W-1:0]     data_in,
    input  logic [N_CH*TAG_W-1:0]      tag_in,
    output logic [N_CH-1:0]            yumi_out,
    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [$clog2(N_CH)-1:0]    cdb_src,
    output logic [31:0]                perf_conflicts
);
    localparam int PTR_W = $clog2(N_CH);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [PTR_W-1:0]  cdb_src_q, cdb_src_d;

    logic              found_hi, found_lo, grant_vld;
    logic [PTR_W-1:0]  idx_hi, idx_lo, grant_idx;
    logic [DATA_W-1:0] gnt_data;
    logic [TAG_W-1:0]  gnt_tag;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (valid_in[i]) begin
                found_lo = 1'b1;
                idx_lo   = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    idx_hi   = PTR_W'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        grant_vld = found_lo && !flush && !reset;
    end

    always_comb begin
        gnt_data = '0;
        gnt_tag  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                gnt_data = data_in[i*DATA_W +: DATA_W];
                gnt_tag  = tag_in[i*TAG_W +: TAG_W];
            end
        end
    end

    assign yumi_out = grant_vld ? (N_CH'(1) << grant_idx) : '0;

    // Payload holds across idle/flush cycles; only the valid bit drops.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_vld;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        if (grant_vld) begin
            rr_ptr_d   = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            cdb_data_d = gnt_data;
            cdb_tag_d  = gnt_tag;
            cdb_src_d  = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        contend;

    always_comb begin
        contend = !flush && ((valid_in & (valid_in - 1'b1)) != '0);
        perf_d  = perf_q;
        if (contend && perf_q != 32'hFFFF_FFFF)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_conflicts = perf_q;
`else
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (N_CH=5, DATA_W=32, TAG_W=4).
module tb_cdb_arbiter;
    localparam int N_CH = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic [N_CH-1:0]    valid_in;
    logic [N_CH*32-1:0] data_in;
    logic [N_CH*4-1:0]  tag_in;
    logic [N_CH-1:0]    yumi_out;
    logic               cdb_valid;
    logic [31:0]        cdb_data;
    logic [3:0]         cdb_tag;
    logic [2:0]         cdb_src;
    logic [31:0]        perf_conflicts;

    int errors = 0;
    int checks = 0;

    cdb_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
        .data_in(data_in), .tag_in(tag_in), .yumi_out(yumi_out),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
        .cdb_src(cdb_src), .perf_conflicts(perf_conflicts)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] d, input logic [3:0] t);
        data_in[i*32 +: 32] = d;
        tag_in[i*4 +: 4]    = t;
    endtask

    task automatic default_payload();
        for (int i = 0; i < N_CH; i++) set_ch(i, 32'hA000_0000 + 32'(i), 4'(i + 8));
    endtask

    task automatic do_reset();
        valid_in = '0;
        flush    = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        default_payload();
        flush    = 1'b0;
        valid_in = 5'b11111;
        reset    = 1'b1;
        #2;
        checks++; if (yumi_out !== 5'b0) begin errors++; $display("FAIL reset_yumi got=%b exp=%b", yumi_out, 5'b0); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", cdb_data); end
        checks++; if (cdb_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got=%h exp=0", cdb_tag); end
        checks++; if (cdb_src !== 3'd0) begin errors++; $display("FAIL reset_src got=%0d exp=0", cdb_src); end
        checks++; if (perf_conflicts !== 32'h0) begin errors++; $display("FAIL reset_perf got=%0d exp=0", perf_conflicts); end
        valid_in = '0;
        reset    = 1'b0;
        step();
    endtask

    task automatic test_single_grant();
        do_reset();
        set_ch(2, 32'hDEAD_BEEF, 4'h7);
        valid_in = 5'b00100;
        #1;
        checks++; if (yumi_out !== 5'b00100) begin errors++; $display("FAIL single_yumi got=%b exp=%b", yumi_out, 5'b00100); end
        step();
        valid_in = '0;
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
        checks++; if (cdb_tag !== 4'h7) begin errors++; $display("FAIL single_tag got=%h exp=7", cdb_tag); end
        checks++; if (cdb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data); end
        checks++; if (cdb_src !== 3'd2) begin errors++; $display("FAIL single_src got=%0d exp=2", cdb_src); end
        // rr_ptr should now be 3: full contention grants channel 3
        valid_in = 5'b11111;
        #1;
        checks++; if (yumi_out !== 5'b01000) begin errors++; $display("FAIL single_rrptr3 got=%b exp=%b", yumi_out, 5'b01000); end
        valid_in = '0;
        step();
        default_payload();
    endtask

    task automatic test_idle_hold();
        do_reset();
        set_ch(1, 32'h1234_5678, 4'h3);
        valid_in = 5'b00010;
        step();
        valid_in = '0;
        #1;
        checks++; if (yumi_out !== 5'b0) begin errors++; $display("FAIL idle_yumi got=%b exp=0", yumi_out); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", cdb_valid); end
        checks++; if (cdb_tag !== 4'h3) begin errors++; $display("FAIL idle_tag got=%h exp=3", cdb_tag); end
        checks++; if (cdb_data !== 32'h1234_5678) begin errors++; $display("FAIL idle_data got=%h exp=12345678", cdb_data); end
        checks++; if (cdb_src !== 3'd1) begin errors++; $display("FAIL idle_src got=%0d exp=1", cdb_src); end
        // rr_ptr held at 2 through the idle cycle
        valid_in = 5'b00111;
        #1;
        checks++; if (yumi_out !== 5'b00100) begin errors++; $display("FAIL idle_rrhold got=%b exp=%b", yumi_out, 5'b00100); end
        valid_in = '0;
        step();
        default_payload();
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_y;
        logic [31:0] exp_perf;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            valid_in = 5'b11111;
            exp_y = 5'b00001 << (k % 5);
            #1;
            checks++; if (yumi_out !== exp_y) begin errors++; $display("FAIL rr_yumi[%0d] got=%b exp=%b", k, yumi_out, exp_y); end
            step();
            checks++; if (cdb_src !== 3'(k % 5)) begin errors++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", k, cdb_src, k % 5); end
        end
        checks++; if (cdb_tag !== 4'h8) begin errors++; $display("FAIL rr_tag got=%h exp=8", cdb_tag); end
`ifdef CDB_PERF_CNT_EN
        exp_perf = 32'd6;
`else
        exp_perf = 32'd0;
`endif
        checks++; if (perf_conflicts !== exp_perf) begin errors++; $display("FAIL rr_perf got=%0d exp=%0d", perf_conflicts, exp_perf); end
        valid_in = '0;
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        valid_in = 5'b01000;
        step();
        valid_in = 5'b00011;
        #1;
        checks++; if (yumi_out !== 5'b00001) begin errors++; $display("FAIL wrap_yumi0 got=%b exp=%b", yumi_out, 5'b00001); end
        step();
        checks++; if (cdb_src !== 3'd0) begin errors++; $display("FAIL wrap_src0 got=%0d exp=0", cdb_src); end
        #1;
        checks++; if (yumi_out !== 5'b00010) begin errors++; $display("FAIL wrap_yumi1 got=%b exp=%b", yumi_out, 5'b00010); end
        step();
        checks++; if (cdb_src !== 3'd1) begin errors++; $display("FAIL wrap_src1 got=%0d exp=1", cdb_src); end
        valid_in = '0;
        step();
    endtask

    task automatic test_flush();
        do_reset();
        valid_in = 5'b00001;
        step();
        flush    = 1'b1;
        valid_in = 5'b01000;
        #1;
        checks++; if (yumi_out !== 5'b0) begin errors++; $display("FAIL flush_yumi got=%b exp=0", yumi_out); end
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL flush_prior_valid got=%b exp=1", cdb_valid); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_next got=%b exp=0", cdb_valid); end
        checks++; if (cdb_src !== 3'd0) begin errors++; $display("FAIL flush_src_hold got=%0d exp=0", cdb_src); end
        flush    = 1'b0;
        valid_in = 5'b11111;
        #1;
        checks++; if (yumi_out !== 5'b00010) begin errors++; $display("FAIL flush_rrhold got=%b exp=%b", yumi_out, 5'b00010); end
        valid_in = '0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        valid_in = 5'b11111;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", cdb_valid); end
        checks++; if (cdb_src !== 3'd0) begin errors++; $display("FAIL areset_src got=%0d exp=0", cdb_src); end
        checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL areset_data got=%h exp=0", cdb_data); end
        checks++; if (yumi_out !== 5'b0) begin errors++; $display("FAIL areset_yumi got=%b exp=0", yumi_out); end
        step();
        reset    = 1'b0;
        valid_in = 5'b10010;
        #1;
        checks++; if (yumi_out !== 5'b00010) begin errors++; $display("FAIL areset_first_grant got=%b exp=%b", yumi_out, 5'b00010); end
        step();
        checks++; if (cdb_src !== 3'd1) begin errors++; $display("FAIL areset_src_after got=%0d exp=1", cdb_src); end
        valid_in = '0;
        step();
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        valid_in = '0;
        data_in  = '0;
        tag_in   = '0;
        test_reset();
        test_single_grant();
        test_idle_hold();
        test_round_robin();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
